// File: rtl/st2_branch_pkg.sv
// Shared encodings for the stage-2 branch path: branch types, comparator results and
// the resolver state machine.
package st2_branch_pkg;

  // Comparator results deliberately reuse the branch-type codes so "taken" is an equality test.
  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_LT    = 2'b01;
  localparam logic [1:0] BR_GT    = 2'b10;
  localparam logic [1:0] BR_EQ    = 2'b11;

  localparam logic [1:0] CMP_NONE = 2'b00;
  localparam logic [1:0] CMP_LT   = 2'b01;
  localparam logic [1:0] CMP_GT   = 2'b10;
  localparam logic [1:0] CMP_EQ   = 2'b11;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRedirect = 2'b01,
    StFlush    = 2'b10
  } rslv_state_e;

  function automatic logic br_taken(input logic [1:0] br_type, input logic [1:0] cmp_result);
    return (br_type != BR_NONE) && (cmp_result == br_type);
  endfunction

endpackage

// File: rtl/st2_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module st2_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/st2_branch_resolver.sv
// Resolves stage-2 branches, hands the taken target to fetch over valid/ready, then squashes
// IF/ID for FLUSH_CYCLES cycles while counting resolved and taken branches.
module st2_branch_resolver
  import st2_branch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              br_valid_i,
  input  logic [1:0]        br_type_i,
  input  logic [1:0]        cmp_result_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              stall_in_i,
  input  logic              redirect_ready_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              flush_if_id_o,
  output logic              hold_st2_o,
  output logic [CNT_W-1:0]  branch_count_o,
  output logic [CNT_W-1:0]  taken_count_o
);

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  rslv_state_e       state_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic [3:0]        flush_cnt_q;

  logic accept;
  logic taken;

  assign accept = (state_q == StIdle) && br_valid_i && !stall_in_i && (br_type_i != BR_NONE);
  assign taken  = br_taken(br_type_i, cmp_result_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      redirect_pc_q <= '0;
      flush_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept && taken) begin
            redirect_pc_q <= br_target_i;
            state_q       <= StRedirect;
          end
        end
        StRedirect: begin
          if (redirect_ready_i) begin
            flush_cnt_q <= FlushInit;
            state_q     <= StFlush;
          end
        end
        StFlush: begin
          flush_cnt_q <= flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign redirect_valid_o = (state_q == StRedirect);
  assign flush_if_id_o    = (state_q == StFlush);
  assign hold_st2_o       = (state_q != StIdle);
  assign redirect_pc_o    = redirect_pc_q;

  st2_sat_counter #(
    .W(CNT_W)
  ) u_branch_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (accept),
    .count_o(branch_count_o)
  );

  st2_sat_counter #(
    .W(CNT_W)
  ) u_taken_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (accept && taken),
    .count_o(taken_count_o)
  );

endmodule

// File: tb/tb_st2_branch_resolver.sv
// Directed bench: instance a uses default parameters, instance b uses FLUSH_CYCLES=3, CNT_W=2.
module tb_st2_branch_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a stimulus/response
  logic        a_rst, a_valid, a_stall, a_ready;
  logic [1:0]  a_type, a_cmp;
  logic [15:0] a_target, a_pc, a_bc, a_tc;
  logic        a_rv, a_flush, a_hold;

  // Instance b stimulus/response
  logic        b_rst, b_valid, b_stall, b_ready;
  logic [1:0]  b_type, b_cmp;
  logic [15:0] b_target, b_pc;
  logic [1:0]  b_bc, b_tc;
  logic        b_rv, b_flush, b_hold;

  st2_branch_resolver dut_a (
    .clk_i           (clk),
    .rst_i           (a_rst),
    .br_valid_i      (a_valid),
    .br_type_i       (a_type),
    .cmp_result_i    (a_cmp),
    .br_target_i     (a_target),
    .stall_in_i      (a_stall),
    .redirect_ready_i(a_ready),
    .redirect_valid_o(a_rv),
    .redirect_pc_o   (a_pc),
    .flush_if_id_o   (a_flush),
    .hold_st2_o      (a_hold),
    .branch_count_o  (a_bc),
    .taken_count_o   (a_tc)
  );

  st2_branch_resolver #(
    .ADDR_W      (16),
    .FLUSH_CYCLES(3),
    .CNT_W       (2)
  ) dut_b (
    .clk_i           (clk),
    .rst_i           (b_rst),
    .br_valid_i      (b_valid),
    .br_type_i       (b_type),
    .cmp_result_i    (b_cmp),
    .br_target_i     (b_target),
    .stall_in_i      (b_stall),
    .redirect_ready_i(b_ready),
    .redirect_valid_o(b_rv),
    .redirect_pc_o   (b_pc),
    .flush_if_id_o   (b_flush),
    .hold_st2_o      (b_hold),
    .branch_count_o  (b_bc),
    .taken_count_o   (b_tc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic rv, input logic fl, input logic hd,
                         input logic [15:0] pc, input logic [15:0] bc, input logic [15:0] tc);
    check({tag, ".rv"}, 32'(a_rv), 32'(rv));
    check({tag, ".flush"}, 32'(a_flush), 32'(fl));
    check({tag, ".hold"}, 32'(a_hold), 32'(hd));
    check({tag, ".pc"}, 32'(a_pc), 32'(pc));
    check({tag, ".bc"}, 32'(a_bc), 32'(bc));
    check({tag, ".tc"}, 32'(a_tc), 32'(tc));
  endtask

  task automatic check_b(input string tag, input logic rv, input logic fl, input logic hd,
                         input logic [15:0] pc, input logic [1:0] bc, input logic [1:0] tc);
    check({tag, ".rv"}, 32'(b_rv), 32'(rv));
    check({tag, ".flush"}, 32'(b_flush), 32'(fl));
    check({tag, ".hold"}, 32'(b_hold), 32'(hd));
    check({tag, ".pc"}, 32'(b_pc), 32'(pc));
    check({tag, ".bc"}, 32'(b_bc), 32'(bc));
    check({tag, ".tc"}, 32'(b_tc), 32'(tc));
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_stall = 1'b0; a_ready = 1'b0;
    a_type = 2'b00; a_cmp = 2'b00; a_target = 16'h0000;
    b_rst = 1'b1; b_valid = 1'b0; b_stall = 1'b0; b_ready = 1'b1;
    b_type = 2'b00; b_cmp = 2'b00; b_target = 16'h0000;
    tick();

    // Reset mid-traffic: park a in REDIRECT, then assert rst for two edges with br_valid held
    a_rst = 1'b0;
    a_valid = 1'b1; a_type = 2'b11; a_cmp = 2'b11; a_target = 16'hBEEF;
    tick();
    check("pre_rst.rv", 32'(a_rv), 32'd1);
    a_rst = 1'b1;
    tick();
    tick();
    a_rst = 1'b0; a_valid = 1'b0;
    check_a("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0);

    // BEQ taken, ready high
    a_ready = 1'b1;
    a_valid = 1'b1; a_type = 2'b11; a_cmp = 2'b11; a_target = 16'h00A4;
    tick();
    a_valid = 1'b0;
    check_a("beq_n1", 1'b1, 1'b0, 1'b1, 16'h00A4, 16'd1, 16'd1);
    tick();
    check_a("beq_n2", 1'b0, 1'b1, 1'b1, 16'h00A4, 16'd1, 16'd1);
    tick();
    check_a("beq_n3", 1'b0, 1'b0, 1'b0, 16'h00A4, 16'd1, 16'd1);

    // BLT not taken
    a_valid = 1'b1; a_type = 2'b01; a_cmp = 2'b10; a_target = 16'h0F0F;
    tick();
    a_valid = 1'b0;
    check_a("blt_nt", 1'b0, 1'b0, 1'b0, 16'h00A4, 16'd2, 16'd1);

    // BGT taken with three cycles of ready low; a second branch is presented meanwhile
    a_ready = 1'b0;
    a_valid = 1'b1; a_type = 2'b10; a_cmp = 2'b10; a_target = 16'h1234;
    tick();
    a_type = 2'b11; a_cmp = 2'b11; a_target = 16'h5555;
    check_a("bp_w0", 1'b1, 1'b0, 1'b1, 16'h1234, 16'd3, 16'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_a($sformatf("bp_w%0d", i), 1'b1, 1'b0, 1'b1, 16'h1234, 16'd3, 16'd2);
    end
    a_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    check_a("bp_flush", 1'b0, 1'b1, 1'b1, 16'h1234, 16'd3, 16'd2);
    tick();
    check_a("bp_idle", 1'b0, 1'b0, 1'b0, 16'h1234, 16'd3, 16'd2);

    // Stalled taken branch is ignored
    a_stall = 1'b1;
    a_valid = 1'b1; a_type = 2'b11; a_cmp = 2'b11; a_target = 16'h7777;
    tick();
    tick();
    check_a("stall", 1'b0, 1'b0, 1'b0, 16'h1234, 16'd3, 16'd2);
    a_stall = 1'b0;

    // br_type none with cmp none is not a branch
    a_type = 2'b00; a_cmp = 2'b00;
    tick();
    a_valid = 1'b0;
    check_a("type_none", 1'b0, 1'b0, 1'b0, 16'h1234, 16'd3, 16'd2);

    // Instance b: five taken branches saturate 2-bit counters, 3-cycle flush each time
    b_rst = 1'b0;
    tick();
    check_b("b_reset", 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      logic [1:0] e;
      e = (i >= 3) ? 2'd3 : 2'(i);
      b_valid = 1'b1; b_type = 2'b10; b_cmp = 2'b10; b_target = 16'(16'h0100 + i);
      tick();
      b_valid = 1'b0;
      check_b($sformatf("b_br%0d_rv", i), 1'b1, 1'b0, 1'b1, 16'(16'h0100 + i), e, e);
      for (int f = 1; f <= 3; f++) begin
        tick();
        check($sformatf("b_br%0d_fl%0d", i, f), 32'(b_flush), 32'd1);
      end
      tick();
      check_b($sformatf("b_br%0d_idle", i), 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i), e, e);
    end

    // Reset during the second flush cycle
    b_valid = 1'b1; b_type = 2'b01; b_cmp = 2'b01; b_target = 16'h0ABC;
    tick();
    b_valid = 1'b0;
    tick();
    tick();
    check_b("b_fl2", 1'b0, 1'b1, 1'b1, 16'h0ABC, 2'd3, 2'd3);
    b_rst = 1'b1;
    tick();
    check_b("b_rst_fl", 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0);
    b_rst = 1'b0;
    tick();
    check_b("b_post_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st2_branch_resolver.md
Name: st2_branch_resolver

Overview:
- Consumer of the stage-2 comparator's 2-bit result.
- Decides whether the stage-2 branch is taken, then hands the target PC to fetch over a valid/ready handshake.
- Flushes the IF/ID register for a programmable number of cycles and keeps branch/taken statistics.
- Sits between stage-2 decode/compare and the fetch PC mux.

Parameters:
- ADDR_W, 16, width of PC/target.
- FLUSH_CYCLES, 1, cycles flush_if_id stays high after redirect accept (legal range 1..15).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  stage 2 holds a branch this cycle.
- br_type  in  2  00 none, 01 BLT, 10 BGT, 11 BEQ.
- cmp_result  in  2  comparator output: 01 less, 10 greater, 11 equal, 00 default.
- br_target  in  ADDR_W  branch target address.
- stall_in  in  1  stage 2 stalled by hazard unit; branch not yet valid to resolve.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  ADDR_W  target PC; stable while redirect_valid=1.
- flush_if_id  out  1  squash the IF/ID register.
- hold_st2  out  1  backpressure to stage 2; high while a redirect is in progress.
- branch_count  out  CNT_W  resolved branches (saturating).
- taken_count  out  CNT_W  taken branches (saturating).

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State=IDLE.
  - redirect_valid, flush_if_id, hold_st2 = 0.
  - redirect_pc = 0.
  - Both counters = 0.
  - Flush counter = 0.
  - Reset overrides any state, including mid-REDIRECT/FLUSH.
- accept = state==IDLE && br_valid && !stall_in && br_type!=00.
- taken = (cmp_result == br_type). cmp_result=00 never takes.
- Register outputs are decoded from the registered state:
  - redirect_valid = (state==REDIRECT).
  - flush_if_id = (state==FLUSH).
  - hold_st2 = (state!=IDLE).
- IDLE:
  - On accept: branch_count+1.
  - If taken: taken_count+1, redirect_pc<=br_target, next=REDIRECT.
  - Not-taken: stay IDLE, no other effect.
- REDIRECT:
  - redirect_valid=1 and redirect_pc held.
  - On redirect_ready=1: flush counter<=FLUSH_CYCLES, next=FLUSH.
  - Otherwise stay; waiting is unbounded.
- FLUSH:
  - flush_if_id=1; counter decrements each cycle.
  - When the counter reaches 1, next=IDLE.
  - flush_if_id is therefore high exactly FLUSH_CYCLES cycles.
- br_valid in REDIRECT/FLUSH is ignored: not counted, no capture.
- Latency for a taken branch accepted at edge N:
  - redirect_valid high from N+1.
  - With ready at N+1: flush_if_id high N+2..N+1+FLUSH_CYCLES.
  - IDLE at N+2+FLUSH_CYCLES; a new branch is accepted at that edge.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - Both increment in the same cycle on a taken branch.
- redirect_pc keeps its last value in IDLE and changes only on a taken accept.
- br_type=00 with br_valid=1 is not a branch: nothing counted.

Decomposition:
- Package st2_branch_pkg holds:
  - br_type encodings BR_NONE/BR_LT/BR_GT/BR_EQ.
  - Matching comparator result encodings CMP_LT/CMP_GT/CMP_EQ/CMP_NONE (shared with the comparator).
  - Resolver state encoding IDLE/REDIRECT/FLUSH.
- One sub-module, st2_sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice for the statistics counters.

Test Plan:
- rst=1 for 2 cycles mid-traffic, then rst=0 -> all outputs 0, state IDLE, counters 0.
- BEQ taken, ready stays high:
  - Stimulus: br_type=11, cmp_result=11, br_target=16'h00A4, br_valid=1 at edge N, redirect_ready=1.
  - Response: redirect_valid=1 with redirect_pc=00A4 at N+1; flush_if_id=1 at N+2 only (FLUSH_CYCLES=1); hold_st2 high N+1..N+2; branch_count=1, taken_count=1.
- BLT not taken: br_type=01, cmp_result=10 -> no redirect, no flush, hold_st2=0; branch_count+1, taken_count unchanged.
- Ready backpressure:
  - Stimulus: taken BGT (10/10), redirect_ready=0 for 3 cycles; a second br_valid is driven during the wait.
  - Response: redirect_valid held 4 cycles with redirect_pc stable; second branch not counted; flush follows the ready cycle.
- stall_in and statistics:
  - stall_in=1 with br_valid=1, a taken match -> ignored entirely.
  - With CNT_W=2, 5 taken branches -> both counters saturate at 3.
- FLUSH_CYCLES=3 with rst asserted in the 2nd FLUSH cycle -> flush_if_id drops at the next edge, state IDLE, counters 0.
